// File: rtl/store_pkg.sv
// Shared constants and helpers for the store path: access-type codes,
// byte-enable patterns, error codes and the fence state encoding.
package store_pkg;

  // Access-type codes (RISC-V funct3 numbering for stores)
  localparam logic [2:0] SB     = 3'b000;
  localparam logic [2:0] SH     = 3'b001;
  localparam logic [2:0] SW     = 3'b010;
  localparam logic [2:0] F3_BAD = 3'b111;  // not exactly one type bit set

  // Byte-enable patterns, bit i = byte lane i
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_LO_H = 4'b0011;
  localparam logic [3:0] BE_HI_H = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Rejection codes reported on st_err_code
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  typedef enum logic {
    FENCE_IDLE  = 1'b0,
    FENCE_DRAIN = 1'b1
  } fence_state_t;

  // Collapse the one-hot type strobes into a funct3 code; anything that is
  // not exactly one-hot maps to F3_BAD so it is rejected as illegal.
  function automatic logic [2:0] type_to_funct3(input logic i_sb, input logic i_sh,
                                                input logic i_sw);
    logic [2:0] v_code;
    case ({i_sb, i_sh, i_sw})
      3'b100:  v_code = SB;
      3'b010:  v_code = SH;
      3'b001:  v_code = SW;
      default: v_code = F3_BAD;
    endcase
    return v_code;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic synchronous FIFO holding formatted store entries. The head entry is
// read asynchronously so a freshly pushed entry is visible the very next cycle
// and back-to-back pops present a new head each cycle.
module store_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;
  assign o_head_data = r_mem[r_rd_ptr];

  // Entry storage: contents need no reset, occupancy is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store-side data path: formats sb/sh/sw requests into lane-replicated data
// plus byte enables, rejects misaligned or illegal requests, posts accepted
// stores into a FIFO that drains over mem_req/mem_ack, and implements a fence
// that blocks new stores until every posted store has drained.
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic              sb,
  input  logic              sh,
  input  logic              sw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic              st_err,
  output logic [1:0]        st_err_code,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              fence_req,
  output logic              fence_done,
  output logic              empty
);

  localparam int EW = (ADDR_W - 2) + 32 + 4;

  fence_state_t      r_state;
  fence_state_t      w_state_next;
  logic [2:0]        w_funct3;
  logic [1:0]        w_a;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;
  logic [1:0]        w_err;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;
  logic [ADDR_W-3:0] w_head_addr;
  logic [31:0]       w_head_wdata;
  logic [3:0]        w_head_be;
  logic              r_st_err;
  logic [1:0]        r_err_code;

  // Format the incoming request and classify it; illegal wins over misaligned
  // because the misalignment rules are only evaluated for a valid type.
  always_comb begin
    w_funct3 = type_to_funct3(sb, sh, sw);
    w_a      = addr[1:0];
    w_wdata  = data_in;
    w_be     = BE_W;
    w_err    = ERR_NONE;
    case (w_funct3)
      SB: begin
        w_wdata = {4{data_in[7:0]}};
        case (w_a)
          2'd0:    w_be = BE_B0;
          2'd1:    w_be = BE_B1;
          2'd2:    w_be = BE_B2;
          default: w_be = BE_B3;
        endcase
      end
      SH: begin
        w_wdata = {2{data_in[15:0]}};
        w_be    = w_a[1] ? BE_HI_H : BE_LO_H;
        if (w_a[0]) w_err = ERR_MISALIGN;
      end
      SW: begin
        if (w_a != 2'b00) w_err = ERR_MISALIGN;
      end
      default: w_err = ERR_ILLEGAL;
    endcase
  end

  // Rejected requests are still consumed by the handshake, just not queued
  assign st_ready = !w_fifo_full && (r_state == FENCE_IDLE);
  assign w_accept = st_valid && st_ready;
  assign w_push   = w_accept && (w_err == ERR_NONE);
  assign w_pop    = mem_req && mem_ack;
  assign w_entry  = {addr[ADDR_W-1:2], w_wdata, w_be};

  store_fifo #(
    .W    (EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_entry),
    .i_pop      (w_pop),
    .o_head_data(w_head),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full)
  );

  // Memory side; fields are forced to zero while idle so stale RAM contents
  // never appear on the bus (e.g. after a reset discards buffered stores).
  assign {w_head_addr, w_head_wdata, w_head_be} = w_head;
  assign empty     = w_fifo_empty;
  assign mem_req   = !w_fifo_empty;
  assign mem_addr  = mem_req ? {w_head_addr, 2'b00} : '0;
  assign mem_wdata = mem_req ? w_head_wdata : '0;
  assign mem_be    = mem_req ? w_head_be : '0;

  // Error pulse one cycle after a rejected handshake; code held until the next error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_err   <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_st_err <= w_accept && (w_err != ERR_NONE);
      if (w_accept && (w_err != ERR_NONE)) r_err_code <= w_err;
    end
  end

  assign st_err      = r_st_err;
  assign st_err_code = r_err_code;

  // Fence state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= FENCE_IDLE;
    else     r_state <= w_state_next;
  end

  // Fence next-state: drain until empty, pulsing fence_done on the exit cycle
  always_comb begin
    w_state_next = r_state;
    fence_done   = 1'b0;
    case (r_state)
      FENCE_IDLE: begin
        if (fence_req) w_state_next = FENCE_DRAIN;
      end
      FENCE_DRAIN: begin
        if (w_fifo_empty) begin
          w_state_next = FENCE_IDLE;
          fence_done   = 1'b1;
        end
      end
      default: w_state_next = FENCE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus a randomized
// run scored against a queue-based reference of posted memory writes.
module tb_store_unit;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic        sb, sh, sw;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        st_err;
  logic [1:0]  st_err_code;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        fence_req;
  logic        fence_done;
  logic        empty;

  int   n_vec = 0;
  int   n_err = 0;
  wr_t  exp_q[$];
  wr_t  got_q[$];
  logic [1:0] exp_code;

  store_unit #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .sb         (sb),
    .sh         (sh),
    .sw         (sw),
    .addr       (addr),
    .data_in    (data_in),
    .st_err     (st_err),
    .st_err_code(st_err_code),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Record every memory write the DUT performs (sampled mid-cycle)
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      got_q.push_back({mem_addr, mem_wdata, mem_be});
      $display("mem write addr=%08h data=%08h be=%04b", mem_addr, mem_wdata, mem_be);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a request should do, derived arithmetically from the rules
  function automatic void ref_store(input logic b, input logic h, input logic w,
                                    input logic [31:0] a, input logic [31:0] d,
                                    output wr_t e, output logic [1:0] err);
    int n;
    n = int'(b) + int'(h) + int'(w);
    e = '0;
    e.a = a & 32'hFFFF_FFFC;
    if (n != 1) err = 2'b10;
    else if ((h && (a % 2) != 0) || (w && (a % 4) != 0)) err = 2'b01;
    else err = 2'b00;
    if (n == 1 && b) begin
      e.d  = {24'b0, d[7:0]} * 32'h0101_0101;
      e.be = 4'(1 << (a % 4));
    end else if (n == 1 && h) begin
      e.d  = {16'b0, d[15:0]} * 32'h0001_0001;
      e.be = ((a % 4) >= 2) ? 4'hC : 4'h3;
    end else if (n == 1 && w) begin
      e.d  = d;
      e.be = 4'hF;
    end
  endfunction

  // Drive one request for one edge; caller has ensured st_ready
  task automatic send(input logic b, input logic h, input logic w,
                      input logic [31:0] a, input logic [31:0] d, output logic [1:0] err);
    wr_t e;
    ref_store(b, h, w, a, d, e, err);
    st_valid = 1'b1; sb = b; sh = h; sw = w; addr = a; data_in = d;
    tick();
    st_valid = 1'b0; sb = 1'b0; sh = 1'b0; sw = 1'b0;
    if (err == 2'b00) exp_q.push_back(e);
    else exp_code = err;
    $display("store sb=%0b sh=%0b sw=%0b addr=%08h data=%08h err=%02b", b, h, w, a, d, err);
  endtask

  task automatic send_legal_rand();
    int t;
    logic [31:0] a;
    logic [1:0] err;
    t = $urandom_range(0, 2);
    a = $urandom;
    if (t == 1) a[0] = 1'b0;
    if (t == 2) a[1:0] = 2'b00;
    send(t == 0, t == 1, t == 2, a, $urandom, err);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    n_vec++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", st_ready); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    n_vec++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_err++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata, mem_be}); end
    n_vec++; if ({st_err, st_err_code, fence_done} !== 4'b0) begin n_err++; $display("FAIL reset_err_fence got=%b exp=0000", {st_err, st_err_code, fence_done}); end
    rst = 1'b0;
    exp_code = 2'b00;
    tick();
    n_vec++; if (st_ready !== 1'b1 || empty !== 1'b1) begin n_err++; $display("FAIL post_reset_idle got=%0b%0b exp=11", st_ready, empty); end
  endtask

  task automatic test_sb();
    logic [1:0] err;
    mem_ack = 1'b1;
    send(1'b1, 1'b0, 1'b0, 32'h103, 32'h0000_00A5, err);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sb_mem_req got=%0b exp=1", mem_req); end
    n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL sb_addr got=%h exp=00000100", mem_addr); end
    n_vec++; if (mem_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mem_wdata); end
    n_vec++; if (mem_be !== 4'b1000) begin n_err++; $display("FAIL sb_be got=%b exp=1000", mem_be); end
    n_vec++; if (st_err !== 1'b0) begin n_err++; $display("FAIL sb_no_err got=%0b exp=0", st_err); end
    tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL sb_empty_after_ack got=%0b exp=1", empty); end
    n_vec++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL sb_write got=%0d writes exp=1 matching", got_q.size()); end
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b0;
  endtask

  task automatic test_sh();
    logic [1:0] err;
    mem_ack = 1'b1;
    send(1'b0, 1'b1, 1'b0, 32'h202, 32'h1234_BEEF, err);
    n_vec++; if (mem_wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata got=%h exp=beefbeef", mem_wdata); end
    n_vec++; if (mem_be !== 4'b1100 || mem_addr !== 32'h200) begin n_err++; $display("FAIL sh_be_addr got=%b/%h exp=1100/00000200", mem_be, mem_addr); end
    tick();
    send(1'b0, 1'b1, 1'b0, 32'h201, 32'h1234_BEEF, err);
    n_vec++; if (st_err !== 1'b1) begin n_err++; $display("FAIL sh_mis_err got=%0b exp=1", st_err); end
    n_vec++; if (st_err_code !== 2'b01) begin n_err++; $display("FAIL sh_mis_code got=%b exp=01", st_err_code); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sh_mis_no_req got=%0b exp=0", mem_req); end
    tick();
    n_vec++; if (st_err !== 1'b0 || st_err_code !== 2'b01) begin n_err++; $display("FAIL sh_err_pulse_hold got=%0b/%b exp=0/01", st_err, st_err_code); end
    n_vec++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL sh_writes got=%0d exp=1", got_q.size()); end
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b0;
  endtask

  task automatic test_illegal_sw();
    logic [1:0] err;
    mem_ack = 1'b1;
    send(1'b0, 1'b0, 1'b0, 32'h300, 32'h1111_1111, err);
    n_vec++; if (st_err !== 1'b1 || st_err_code !== 2'b10) begin n_err++; $display("FAIL ill_none got=%0b/%b exp=1/10", st_err, st_err_code); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ill_no_req got=%0b exp=0", mem_req); end
    send(1'b0, 1'b1, 1'b1, 32'h301, 32'h2222_2222, err);
    n_vec++; if (st_err !== 1'b1 || st_err_code !== 2'b10) begin n_err++; $display("FAIL ill_priority got=%0b/%b exp=1/10", st_err, st_err_code); end
    send(1'b0, 1'b0, 1'b1, 32'h302, 32'h3333_3333, err);
    n_vec++; if (st_err !== 1'b1 || st_err_code !== 2'b01) begin n_err++; $display("FAIL sw_mis got=%0b/%b exp=1/01", st_err, st_err_code); end
    send(1'b0, 1'b0, 1'b1, 32'h300, 32'hDEAD_BEEF, err);
    n_vec++; if (mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b1111) begin n_err++; $display("FAIL sw_word got=%h/%b exp=deadbeef/1111", mem_wdata, mem_be); end
    n_vec++; if (st_err !== 1'b0 || st_err_code !== 2'b01) begin n_err++; $display("FAIL sw_ok_err got=%0b/%b exp=0/01", st_err, st_err_code); end
    tick();
    n_vec++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL sw_writes got=%0d exp=1", got_q.size()); end
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b0;
  endtask

  task automatic test_full_stall();
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d got=%0b exp=1", k, st_ready); end
      send_legal_rand();
    end
    n_vec++; if (st_ready !== 1'b0 || mem_req !== 1'b1) begin n_err++; $display("FAIL full_flags got=%0b/%0b exp=0/1", st_ready, mem_req); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if ({mem_addr, mem_wdata, mem_be} !== exp_q[0]) begin n_err++; $display("FAIL stall_stable_%0d got=%h exp=%h", k, {mem_addr, mem_wdata, mem_be}, exp_q[0]); end
      tick();
    end
    // pop while full, with a push attempt that must be refused
    st_valid = 1'b1; sb = 1'b1; addr = $urandom; data_in = $urandom;
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0; sb = 1'b0;
    n_vec++; if (st_err !== 1'b0) begin n_err++; $display("FAIL blocked_push_err got=%0b exp=0", st_err); end
    for (int j = 1; j < 4; j++) begin
      n_vec++; if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_be} !== exp_q[j]) begin n_err++; $display("FAIL drain_head_%0d got=%h exp=%h", j, {mem_addr, mem_wdata, mem_be}, exp_q[j]); end
      tick();
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    n_vec++; if (got_q.size() != 4) begin n_err++; $display("FAIL drain_count got=%0d exp=4", got_q.size()); end
    for (int j = 0; j < 4 && j < got_q.size(); j++) begin
      n_vec++; if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL drain_order_%0d got=%h exp=%h", j, got_q[j], exp_q[j]); end
    end
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b0;
  endtask

  task automatic test_fence();
    logic [1:0] err;
    int pulses;
    int pulse_at;
    logic rdy[6];
    mem_ack = 1'b0;
    send(1'b0, 1'b0, 1'b1, 32'h400, $urandom, err);
    send(1'b0, 1'b1, 1'b0, 32'h502, $urandom, err);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    n_vec++; if (st_ready !== 1'b0 || fence_done !== 1'b0) begin n_err++; $display("FAIL fence_block got=%0b/%0b exp=0/0", st_ready, fence_done); end
    st_valid = 1'b1; sw = 1'b1; addr = 32'h600;
    tick();
    st_valid = 1'b0; sw = 1'b0;
    n_vec++; if (st_err !== 1'b0 || mem_req !== 1'b1) begin n_err++; $display("FAIL fence_hold got=%0b/%0b exp=0/1", st_err, mem_req); end
    mem_ack = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i < 6; i++) begin
      tick();
      rdy[i] = st_ready;
      if (fence_done === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    n_vec++; if (pulses != 1 || pulse_at != 2) begin n_err++; $display("FAIL fence_done_pulse got=%0d@%0d exp=1@2", pulses, pulse_at); end
    n_vec++; if (rdy[2] !== 1'b0 || rdy[3] !== 1'b1) begin n_err++; $display("FAIL fence_ready_after got=%0b%0b exp=01", rdy[2], rdy[3]); end
    n_vec++; if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin n_err++; $display("FAIL fence_writes got=%0d exp=2", got_q.size()); end
    got_q.delete(); exp_q.delete();
    // fence with nothing buffered
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    n_vec++; if (fence_done !== 1'b1 || st_ready !== 1'b0) begin n_err++; $display("FAIL fence_empty got=%0b/%0b exp=1/0", fence_done, st_ready); end
    tick();
    n_vec++; if (fence_done !== 1'b0 || st_ready !== 1'b1) begin n_err++; $display("FAIL fence_empty_exit got=%0b/%0b exp=0/1", fence_done, st_ready); end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) send_legal_rand();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_pre got=%0b exp=1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_code = 2'b00;
    n_vec++; if (mem_req !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin n_err++; $display("FAIL rmid_state got=%0b%0b%0b exp=011", mem_req, empty, st_ready); end
    n_vec++; if (st_err_code !== 2'b00) begin n_err++; $display("FAIL rmid_code got=%b exp=00", st_err_code); end
    mem_ack = 1'b1;
    repeat (4) tick();
    n_vec++; if (got_q.size() != 0 || mem_req !== 1'b0) begin n_err++; $display("FAIL rmid_no_writes got=%0d exp=0", got_q.size()); end
    got_q.delete();
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    logic acc, pop, b, h, w;
    logic [1:0] err;
    logic [31:0] a, d;
    wr_t e, m, g;
    int r;
    for (int i = 0; i < 300; i++) begin
      n_vec++; if (st_ready !== (exp_q.size() < 4)) begin n_err++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", i, st_ready, exp_q.size() < 4); end
      n_vec++; if (mem_req !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_mem_req[%0d] got=%0b exp=%0b", i, mem_req, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_vec++; if ({mem_addr, mem_wdata, mem_be} !== exp_q[0]) begin n_err++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, {mem_addr, mem_wdata, mem_be}, exp_q[0]); end
      end
      r = $urandom_range(0, 9);
      b = 1'b0; h = 1'b0; w = 1'b0;
      if (r == 1) begin
        b = 1'b1; h = 1'b1;
      end else if (r != 0) begin
        case ($urandom_range(0, 2))
          0: b = 1'b1;
          1: h = 1'b1;
          default: w = 1'b1;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom;
      st_valid = 1'($urandom_range(0, 1));
      sb = b; sh = h; sw = w; addr = a; data_in = d;
      mem_ack = ($urandom_range(0, 3) != 0);
      acc = st_valid && (exp_q.size() < 4);
      pop = mem_ack && (exp_q.size() != 0);
      ref_store(b, h, w, a, d, e, err);
      tick();
      if (pop) begin
        m = exp_q.pop_front();
        n_vec++;
        if (got_q.size() == 0) begin
          n_err++; $display("FAIL rnd_write_missing[%0d] got=none exp=%h", i, m);
        end else begin
          g = got_q.pop_front();
          if (g !== m) begin n_err++; $display("FAIL rnd_write[%0d] got=%h exp=%h", i, g, m); end
        end
      end
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL rnd_extra_write[%0d] got=%0d exp=0", i, got_q.size()); got_q.delete(); end
      if (acc && err == 2'b00) exp_q.push_back(e);
      if (acc && err != 2'b00) exp_code = err;
      if (acc) $display("rand store sb=%0b sh=%0b sw=%0b addr=%08h data=%08h err=%02b", b, h, w, a, d, err);
      n_vec++; if (st_err !== (acc && err != 2'b00)) begin n_err++; $display("FAIL rnd_st_err[%0d] got=%0b exp=%0b", i, st_err, acc && err != 2'b00); end
      n_vec++; if (st_err_code !== exp_code) begin n_err++; $display("FAIL rnd_code[%0d] got=%b exp=%b", i, st_err_code, exp_code); end
    end
    st_valid = 1'b0; sb = 1'b0; sh = 1'b0; sw = 1'b0;
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pop = (exp_q.size() != 0);
      tick();
      if (pop) begin
        m = exp_q.pop_front();
        n_vec++;
        if (got_q.size() == 0) begin
          n_err++; $display("FAIL rnd_tail_missing got=none exp=%h", m);
        end else begin
          g = got_q.pop_front();
          if (g !== m) begin n_err++; $display("FAIL rnd_tail got=%h exp=%h", g, m); end
        end
      end
    end
    n_vec++; if (empty !== 1'b1 || got_q.size() != 0) begin n_err++; $display("FAIL rnd_final got=%0b/%0d exp=1/0", empty, got_q.size()); end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; sb = 1'b0; sh = 1'b0; sw = 1'b0;
    addr = '0; data_in = '0; mem_ack = 1'b0; fence_req = 1'b0;
    exp_code = 2'b00;
    test_reset();
    test_sb();
    test_sh();
    test_illegal_sw();
    test_full_stall();
    test_fence();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
